// File: rtl/reg_wr_arbiter_pkg.sv
// Shared constants for the register write arbiter: FSM encodings and the
// width helper used to size the round-robin pointer and burst counter.
package reg_wr_arbiter_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    // Bits needed to hold values 0..v-1, never less than one bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/reg_wr_arbiter_if.sv
// Requester-side bus of the register write arbiter: requests, locks and
// packed write data in; grant and shared-register d/en pair out.
interface reg_wr_arbiter_if #(
    parameter int N = 4,
    parameter int W = 8
);
    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic           en_out;
    logic [W-1:0]   d_out;
    logic           busy;

    modport master (
        output req, lock, wdata,
        input  gnt, en_out, d_out, busy
    );

    modport slave (
        input  req, lock, wdata,
        output gnt, en_out, d_out, busy
    );
endinterface

// File: rtl/reg_wr_arbiter_rr_pick.sv
// Rotate-priority search: first requester at or after ptr, wrapping at N.
module reg_wr_arbiter_rr_pick
    import reg_wr_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          valid,
    output logic [PW-1:0] winner
);

    int idx;

    // NOTE: every output gets a default before the search so no latch is inferred.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        // Scan from the far end back toward ptr so the nearest requester wins last.
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                valid  = 1'b1;
                winner = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter sharing one enabled register among N requesters, with
// bounded burst locking. All outputs are registered one cycle after sampling.
module reg_wr_arbiter
    import reg_wr_arbiter_pkg::*;
#(
    parameter int N         = 4,
    parameter int W         = 8,
    parameter int MAX_BURST = 4
) (
    input logic             clk,
    input logic             rst,
    reg_wr_arbiter_if.slave bus
);

    localparam int PW = clog2(N);
    localparam int BW = clog2(MAX_BURST + 1);

    logic [0:0]    state_q, state_n;
    logic [PW-1:0] owner_q, owner_n;
    logic [PW-1:0] ptr_q, ptr_n;
    logic [BW-1:0] cnt_q, cnt_n;
    logic [N-1:0]  gnt_q, gnt_n;
    logic          en_q, en_n;
    logic [W-1:0]  d_q, d_n;

    logic          keep;
    logic [PW-1:0] owner_inc;
    logic [PW-1:0] pick_ptr;
    logic          pick_valid;
    logic [PW-1:0] pick_winner;

    assign keep = (state_q == ST_OWN) && bus.req[owner_q] && bus.lock[owner_q]
                  && (cnt_q < BW'(MAX_BURST));

    assign owner_inc = (int'(owner_q) == N - 1) ? '0 : owner_q + 1'b1;

    // A releasing owner arbitrates in the same edge from the slot after itself.
    assign pick_ptr = (state_q == ST_OWN) ? owner_inc : ptr_q;

    reg_wr_arbiter_rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req    (bus.req),
        .ptr    (pick_ptr),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    always_comb begin
        state_n = state_q;
        owner_n = owner_q;
        ptr_n   = ptr_q;
        cnt_n   = cnt_q;
        gnt_n   = gnt_q;
        en_n    = en_q;
        d_n     = d_q;

        if (keep) begin
            cnt_n = cnt_q + 1'b1;
            en_n  = 1'b1;
            d_n   = bus.wdata[int'(owner_q)*W +: W];
        end else begin
            if (state_q == ST_OWN) ptr_n = owner_inc;
            if (pick_valid) begin
                state_n = ST_OWN;
                owner_n = pick_winner;
                gnt_n   = N'(1) << pick_winner;
                en_n    = 1'b1;
                d_n     = bus.wdata[int'(pick_winner)*W +: W];
                cnt_n   = BW'(1);
            end else begin
                // Idle: d_out keeps the last written value.
                state_n = ST_IDLE;
                gnt_n   = '0;
                en_n    = 1'b0;
                cnt_n   = '0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            en_q    <= 1'b0;
            d_q     <= '0;
        end else begin
            state_q <= state_n;
            owner_q <= owner_n;
            ptr_q   <= ptr_n;
            cnt_q   <= cnt_n;
            gnt_q   <= gnt_n;
            en_q    <= en_n;
            d_q     <= d_n;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.en_out = en_q;
    assign bus.d_out  = d_q;
    assign bus.busy   = en_q;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Directed bench for reg_wr_arbiter (N=4, W=8, MAX_BURST=4) with
// hand-computed expected grant, enable and data values.
module tb_reg_wr_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    reg_wr_arbiter_if #(.N(4), .W(8)) bus ();

    reg_wr_arbiter #(
        .N         (4),
        .W         (8),
        .MAX_BURST (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic e, input logic [7:0] d);
        chk({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
        chk({tag, ".en"}, 32'(bus.en_out), 32'(e));
        chk({tag, ".d"}, 32'(bus.d_out), 32'(d));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(e));
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bus.req  = '0;
        bus.lock = '0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        bus.req   = 4'b1111;
        bus.lock  = 4'b1111;
        bus.wdata = 32'h13121110;
        #1;

        // Reset dominates full request/lock.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out($sformatf("reset%0d", i), 4'b0000, 1'b0, 8'h00);
        end

        // Single unlocked write, then idle holding d_out.
        rst       = 1'b0;
        bus.req   = 4'b0001;
        bus.lock  = 4'b0000;
        bus.wdata = 32'h000000A5;
        step();
        expect_out("single", 4'b0001, 1'b1, 8'hA5);
        bus.req = 4'b0000;
        step();
        expect_out("single_idle", 4'b0000, 1'b0, 8'hA5);

        // Round robin with all requesting, no locks.
        do_reset();
        bus.req   = 4'b1111;
        bus.wdata = 32'h13121110;
        step(); expect_out("rr0", 4'b0001, 1'b1, 8'h10);
        step(); expect_out("rr1", 4'b0010, 1'b1, 8'h11);
        step(); expect_out("rr2", 4'b0100, 1'b1, 8'h12);
        step(); expect_out("rr3", 4'b1000, 1'b1, 8'h13);
        step(); expect_out("rr4", 4'b0001, 1'b1, 8'h10);

        // Burst cap: owner 0 locked for exactly MAX_BURST cycles.
        do_reset();
        bus.req  = 4'b0011;
        bus.lock = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            step(); expect_out($sformatf("cap%0d", i), 4'b0001, 1'b1, 8'h10);
        end
        step(); expect_out("cap_rel", 4'b0010, 1'b1, 8'h11);
        step(); expect_out("cap_back", 4'b0001, 1'b1, 8'h10);

        // Early unlock after two held cycles moves on without a bubble.
        do_reset();
        bus.req  = 4'b0011;
        bus.lock = 4'b0001;
        step(); expect_out("early0", 4'b0001, 1'b1, 8'h10);
        step(); expect_out("early1", 4'b0001, 1'b1, 8'h10);
        bus.lock = 4'b0000;
        step(); expect_out("early_rel", 4'b0010, 1'b1, 8'h11);

        // Lone locked requester: data follows wdata, re-granted after the cap.
        do_reset();
        bus.req  = 4'b0001;
        bus.lock = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            bus.wdata = 32'h13121100 | 32'(8'h40 + i);
            step(); expect_out($sformatf("lone%0d", i), 4'b0001, 1'b1, 8'h40 + 8'(i));
        end
        bus.wdata = 32'h13121110;

        // Owner dropping req mid-burst releases at that edge; idle follows.
        bus.req = 4'b0000;
        step(); expect_out("drop", 4'b0000, 1'b0, 8'h44);

        // Non-owner lock has no effect until that requester wins.
        do_reset();
        bus.req  = 4'b0011;
        bus.lock = 4'b0010;
        step(); expect_out("nolock0", 4'b0001, 1'b1, 8'h10);
        for (int i = 0; i < 4; i++) begin
            step(); expect_out($sformatf("nolock_b%0d", i), 4'b0010, 1'b1, 8'h11);
        end
        step(); expect_out("nolock_end", 4'b0001, 1'b1, 8'h10);

        // Lock without req is ignored: requester 0 re-wins each cycle.
        do_reset();
        bus.req  = 4'b0001;
        bus.lock = 4'b0010;
        step(); expect_out("lk_noreq0", 4'b0001, 1'b1, 8'h10);
        step(); expect_out("lk_noreq1", 4'b0001, 1'b1, 8'h10);

        // Reset in the middle of a locked burst of requester 2.
        do_reset();
        bus.req  = 4'b0100;
        bus.lock = 4'b0100;
        step(); expect_out("mid0", 4'b0100, 1'b1, 8'h12);
        step(); expect_out("mid1", 4'b0100, 1'b1, 8'h12);
        rst = 1'b1;
        step(); expect_out("mid_rst", 4'b0000, 1'b0, 8'h00);
        rst      = 1'b0;
        bus.req  = 4'b1010;
        bus.lock = 4'b0000;
        step(); expect_out("mid_r1", 4'b0010, 1'b1, 8'h11);
        step(); expect_out("mid_r3", 4'b1000, 1'b1, 8'h13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_wr_arbiter.md
Name: reg_wr_arbiter

Overview:
- Round-robin write arbiter that shares one enabled register (dff_en-style storage element, d/en inputs) among N requesters.
- Each cycle it selects at most one requester and drives the register's en/d pair.
- A requester can lock the resource for a bounded burst of back-to-back writes.
- Sits between the requesting datapath stages and the shared enabled-flop register bank.

Parameters:
- N, 4: number of requesters (2..8).
- W, 8: data width written into the shared register.
- MAX_BURST, 4: maximum consecutive cycles one locked owner may hold the grant (>=1; 1 disables locking).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  per-requester write request.
- lock  input  N  per-requester burst-lock request; ignored unless the matching req is high.
- wdata  input  N*W  packed write data; requester i occupies bits [i*W +: W].
- gnt  output  N  one-hot grant, registered; all zero when idle.
- en_out  output  1  enable to the shared register, registered; equals |gnt.
- d_out  output  W  data to the shared register, registered.
- busy  output  1  an owner currently holds the grant (equals en_out).

Behaviour:
- Reset: one clock and one reset. rst is synchronous and active-high; it is sampled only on the rising edge of clk. On the reset edge gnt=0, en_out=0, d_out=0, busy=0, the round-robin pointer ptr=0, burst_cnt=0 and there is no owner. Reset takes priority over everything, including a burst in progress.
- Registered decision: req, lock and wdata are sampled at edge t. gnt, en_out and d_out reflect that decision from t+1. Latency is 1 cycle.
- Internal state: owner index, owner_valid, ptr (clog2(N) bits), burst_cnt (clog2(MAX_BURST+1) bits).
- The two states are IDLE (owner_valid=0) and OWN (owner_valid=1).
- Keep rule, OWN: the current owner keeps the grant if req[owner] and lock[owner] are both high at the edge and burst_cnt < MAX_BURST. When it keeps the grant: gnt is unchanged, en_out=1, d_out=wdata[owner], burst_cnt increments.
- Release: in OWN, if the keep rule fails, the owner releases. ptr becomes (owner+1) mod N, and the block arbitrates in the same edge using the new ptr.
- Arbitration (from IDLE or on release): the winner is the first i with req[i]=1, scanning ptr, ptr+1, ... wrapping at N.
  - If a winner exists: owner=winner, gnt=onehot(winner), en_out=1, d_out=wdata[winner], burst_cnt=1, state OWN.
  - If no requester: gnt=0, en_out=0, d_out holds its last value, state IDLE. ptr is unchanged in IDLE.
- Back-to-back grants: no idle bubble occurs between owners.
- A single-cycle (unlocked) grant releases on the next edge.
- A forced release at MAX_BURST gives the releasing requester lowest priority. If it is the only requester, it is re-granted on the next edge with burst_cnt=1.
- The owner dropping req mid-burst releases at that edge.
- A lock asserted without req is ignored.
- The lock of a non-owner has no effect until that requester wins.
- With MAX_BURST=1, every grant lasts exactly one cycle.
- Invariants: gnt is always one-hot or zero. en_out == |gnt == busy.

Decomposition:
- Shared constants file: state encodings IDLE/OWN, and a clog2 function used for the ptr and burst_cnt widths.
- One natural combinational sub-module, rr_pick. Inputs: req[N] and ptr. Outputs: valid and winner index, computed with rotate-priority search.
- reg_wr_arbiter holds all registers and the keep/release logic.

Test Plan:
- Reset: hold rst=1 with req=4'b1111 and lock=4'b1111 for 3 cycles -> gnt=0, en_out=0, d_out=8'h00, busy=0 at every edge.
- Single write: req=4'b0001, wdata[0]=8'hA5 for 1 cycle -> next cycle gnt=4'b0001, en_out=1, d_out=8'hA5; the following cycle gnt=0, en_out=0, d_out stays 8'hA5.
- Round robin: req=4'b1111, lock=0, wdata[i]=8'h10+i held -> gnt sequence 0001, 0010, 0100, 1000, 0001 and d_out sequence 10, 11, 12, 13, 10, with en_out constantly 1.
- Burst cap: req=4'b0011, lock=4'b0001, MAX_BURST=4 -> gnt=0001 for exactly 4 cycles, then 0010 for 1 cycle, then 0001 again.
- Early unlock: same stimulus, but lock[0] deasserted after owner 0 has held 2 cycles -> gnt moves to 0010 on the next edge with no idle cycle.
- Reset mid-burst: rst=1 for one edge during a locked burst of requester 2, then req=4'b1010 -> reset edge gives gnt=0, then requester 1 wins first (ptr=0), then requester 3.
